mem_traffic_gen: RTL and testbench

Self-checking traffic source for the DDR2 memory path. It sits upstream of the request-receiving stage and drives write and read requests over the `write_req`/`read_req` handshake. It also acts as the read-return consumer: it pops the return buffer and compares each returned line against the address-derived pattern it wrote. Pass and error counters expose progress to the board switches and LEDs and to the simulation bench.

---
 rtl/mem_traffic_pkg.sv | 31 +++
 rtl/return_checker.sv | 62 ++++++
 rtl/mem_traffic_gen.sv | 179 +++++++++++++++++
 tb/tb_mem_traffic_gen.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_traffic_pkg.sv
// Shared types and the address-derived line pattern used by the DDR2 traffic generator.
package mem_traffic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WRITE  = 3'd1,
    ST_WDRAIN = 3'd2,
    ST_READ   = 3'd3,
    ST_RDRAIN = 3'd4
  } state_t;

  localparam int LANE_WIDTH    = 32;
  localparam int NUM_LANES     = 4;
  localparam int LINE_WIDTH    = LANE_WIDTH * NUM_LANES;
  localparam int PATTERN_ADX_W = 24;
  localparam int PASS_TAG_W    = 8;

  // Lane k carries {pass ^ k, adx}; the lane index makes a lane swap visible.
  function automatic logic [LINE_WIDTH-1:0] line_pattern(
    input logic [PATTERN_ADX_W-1:0] adx,
    input logic [PASS_TAG_W-1:0]    pass
  );
    logic [LINE_WIDTH-1:0] pat;
    pat = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      pat[k*LANE_WIDTH +: LANE_WIDTH] = {pass ^ PASS_TAG_W'(k), adx};
    end
    return pat;
  endfunction

endpackage

// File: rtl/return_checker.sv
// Read-return consumer: pops the return buffer at most every other cycle and
// checks each line against the expected pattern and the legal address window.
module return_checker
  import mem_traffic_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 27,
  parameter int                    DATA_WIDTH  = 128,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADX    = '0,
  parameter int                    ADDR_STRIDE = 16,
  parameter int                    NUM_LINES   = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  has_return_data,
  input  logic [DATA_WIDTH-1:0] return_data,
  input  logic [ADDR_WIDTH-1:0] return_adx,
  input  logic [PASS_TAG_W-1:0] pass_tag,
  output logic                  get_return_data,
  output logic                  pop,
  output logic [15:0]           error_count,
  output logic                  error_flag
);

  localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(ADDR_STRIDE);
  localparam logic [ADDR_WIDTH-1:0] SPAN_A   = ADDR_WIDTH'((NUM_LINES - 1) * ADDR_STRIDE);

  logic                  borrow_s;
  logic [ADDR_WIDTH-1:0] offset_s;
  logic                  in_range_s;
  logic                  aligned_s;
  logic [DATA_WIDTH-1:0] expected_s;
  logic                  mismatch_s;

  // Borrow from the base subtraction flags addresses below the window.
  always_comb begin
    {borrow_s, offset_s} = {1'b0, return_adx} - {1'b0, BASE_ADX};
    in_range_s = !borrow_s && (offset_s <= SPAN_A);
    aligned_s  = ((offset_s % STRIDE_A) == '0);
    expected_s = line_pattern(return_adx[PATTERN_ADX_W-1:0], pass_tag);
    mismatch_s = (return_data != expected_s) || !in_range_s || !aligned_s;
  end

  assign pop = get_return_data;

  // Pop pulse with a forced low cycle, and the registered compare result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      get_return_data <= 1'b0;
      error_count     <= 16'd0;
      error_flag      <= 1'b0;
    end else begin
      get_return_data <= has_return_data && !get_return_data;
      if (get_return_data && mismatch_s) begin
        error_flag <= 1'b1;
        if (error_count != 16'hFFFF) begin
          error_count <= error_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_traffic_gen.sv
// DDR2 path traffic source: writes a pattern over a window, drains, reads it
// back under an outstanding-read cap, and counts completed passes.
module mem_traffic_gen
  import mem_traffic_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 27,
  parameter int                    DATA_WIDTH      = 128,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADX        = '0,
  parameter int                    ADDR_STRIDE     = 16,
  parameter int                    NUM_LINES       = 1024,
  parameter int                    MAX_OUTSTANDING = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  write_allowed,
  input  logic                  read_allowed,
  input  logic                  writes_pending,
  input  logic                  reads_pending,
  output logic                  write_req,
  output logic                  read_req,
  output logic [ADDR_WIDTH-1:0] tr_adx,
  output logic [DATA_WIDTH-1:0] tr_wr_data,
  input  logic                  has_return_data,
  input  logic [DATA_WIDTH-1:0] return_data,
  input  logic [ADDR_WIDTH-1:0] return_adx,
  output logic                  get_return_data,
  output logic                  busy,
  output logic [15:0]           pass_count,
  output logic [15:0]           error_count,
  output logic                  error_flag
);

  localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_LINES - 1);
  localparam logic [OUT_W-1:0]      OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [ADDR_WIDTH-1:0] STRIDE_A = ADDR_WIDTH'(ADDR_STRIDE);

  state_t                state_r;
  logic [IDX_W-1:0]      idx_r;
  logic                  enable_r;
  logic [OUT_W-1:0]      outstanding_r;
  logic [OUT_W-1:0]      outstanding_next_s;
  logic                  pop_s;
  logic                  wr_accept_s;
  logic                  rd_accept_s;
  logic [ADDR_WIDTH-1:0] next_adx_s;
  logic [15:0]           next_pass_s;
  logic                  unused_s;

  assign unused_s = reads_pending;

  return_checker #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .BASE_ADX    (BASE_ADX),
    .ADDR_STRIDE (ADDR_STRIDE),
    .NUM_LINES   (NUM_LINES)
  ) u_return_checker (
    .clk             (clk),
    .resetn          (resetn),
    .has_return_data (has_return_data),
    .return_data     (return_data),
    .return_adx      (return_adx),
    .pass_tag        (pass_count[PASS_TAG_W-1:0]),
    .get_return_data (get_return_data),
    .pop             (pop_s),
    .error_count     (error_count),
    .error_flag      (error_flag)
  );

  // Handshake decode and next outstanding count; a pop with nothing in flight is ignored.
  always_comb begin
    wr_accept_s = write_req && write_allowed;
    rd_accept_s = read_req && read_allowed;
    next_adx_s  = tr_adx + STRIDE_A;
    next_pass_s = pass_count + 16'd1;
    if (rd_accept_s && !(pop_s && (outstanding_r != '0))) begin
      outstanding_next_s = outstanding_r + OUT_W'(1);
    end else if (!rd_accept_s && pop_s && (outstanding_r != '0)) begin
      outstanding_next_s = outstanding_r - OUT_W'(1);
    end else begin
      outstanding_next_s = outstanding_r;
    end
  end

  // Reads issued but not yet popped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      outstanding_r <= '0;
    end else begin
      outstanding_r <= outstanding_next_s;
    end
  end

  // Pass sequencer with registered request outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      idx_r      <= '0;
      enable_r   <= 1'b0;
      write_req  <= 1'b0;
      read_req   <= 1'b0;
      tr_adx     <= '0;
      tr_wr_data <= '0;
      busy       <= 1'b0;
      pass_count <= 16'd0;
    end else begin
      enable_r <= enable;
      case (state_r)
        ST_IDLE: begin
          if (enable_r) begin
            state_r    <= ST_WRITE;
            idx_r      <= '0;
            tr_adx     <= BASE_ADX;
            tr_wr_data <= line_pattern(BASE_ADX[PATTERN_ADX_W-1:0], pass_count[PASS_TAG_W-1:0]);
            write_req  <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_WRITE: begin
          if (wr_accept_s) begin
            if (idx_r == LAST_IDX) begin
              state_r   <= ST_WDRAIN;
              write_req <= 1'b0;
            end else begin
              idx_r      <= idx_r + IDX_W'(1);
              tr_adx     <= next_adx_s;
              tr_wr_data <= line_pattern(next_adx_s[PATTERN_ADX_W-1:0], pass_count[PASS_TAG_W-1:0]);
            end
          end
        end
        ST_WDRAIN: begin
          if (!writes_pending) begin
            state_r  <= ST_READ;
            idx_r    <= '0;
            tr_adx   <= BASE_ADX;
            read_req <= (outstanding_next_s < OUT_MAX);
          end
        end
        ST_READ: begin
          if (rd_accept_s && (idx_r == LAST_IDX)) begin
            state_r  <= ST_RDRAIN;
            read_req <= 1'b0;
          end else begin
            if (rd_accept_s) begin
              idx_r  <= idx_r + IDX_W'(1);
              tr_adx <= next_adx_s;
            end
            read_req <= (outstanding_next_s < OUT_MAX);
          end
        end
        ST_RDRAIN: begin
          if (outstanding_r == '0) begin
            pass_count <= next_pass_s;
            if (enable_r) begin
              state_r    <= ST_WRITE;
              idx_r      <= '0;
              tr_adx     <= BASE_ADX;
              tr_wr_data <= line_pattern(BASE_ADX[PATTERN_ADX_W-1:0], next_pass_s[PASS_TAG_W-1:0]);
              write_req  <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          write_req <= 1'b0;
          read_req  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_traffic_gen.sv
// Directed bench for mem_traffic_gen with a loopback memory / return-buffer model.
module tb_mem_traffic_gen;

  logic         clk;
  logic         resetn;
  logic         enable;
  logic         write_allowed;
  logic         read_allowed;
  logic         writes_pending;
  logic         reads_pending;
  logic         write_req;
  logic         read_req;
  logic [26:0]  tr_adx;
  logic [127:0] tr_wr_data;
  logic         has_return_data;
  logic [127:0] return_data;
  logic [26:0]  return_adx;
  logic         get_return_data;
  logic         busy;
  logic [15:0]  pass_count;
  logic [15:0]  error_count;
  logic         error_flag;

  int checks = 0;
  int failures = 0;

  mem_traffic_gen #(
    .ADDR_WIDTH(27), .DATA_WIDTH(128), .BASE_ADX(27'd0),
    .ADDR_STRIDE(16), .NUM_LINES(4), .MAX_OUTSTANDING(2)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable),
    .write_allowed(write_allowed), .read_allowed(read_allowed),
    .writes_pending(writes_pending), .reads_pending(reads_pending),
    .write_req(write_req), .read_req(read_req),
    .tr_adx(tr_adx), .tr_wr_data(tr_wr_data),
    .has_return_data(has_return_data), .return_data(return_data),
    .return_adx(return_adx), .get_return_data(get_return_data),
    .busy(busy), .pass_count(pass_count),
    .error_count(error_count), .error_flag(error_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] exp_pattern(input logic [26:0] a, input logic [7:0] p);
    return {p ^ 8'h03, a[23:0], p ^ 8'h02, a[23:0], p ^ 8'h01, a[23:0], p, a[23:0]};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Loopback memory and return buffer.
  typedef struct { logic [26:0] adx; logic [127:0] data; } ret_t;
  ret_t         q[$];
  logic [127:0] mem[4];
  int           wcount[4] = '{default: 0};
  int           pop_cnt = 0;
  logic         corrupt_en = 1'b0;
  logic         hold_return = 1'b0;
  logic         inject_valid = 1'b0;
  logic [26:0]  inject_adx = 27'd0;
  logic [127:0] inject_data = 128'd0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q.delete();
      has_return_data <= 1'b0;
    end else begin
      if (write_req && write_allowed) begin
        mem[tr_adx[5:4]]    <= (corrupt_en && tr_adx == 27'd32) ? (tr_wr_data ^ 128'd1) : tr_wr_data;
        wcount[tr_adx[5:4]] <= wcount[tr_adx[5:4]] + 1;
      end
      if (get_return_data && q.size() > 0) begin
        q.delete(0);
        pop_cnt <= pop_cnt + 1;
      end
      if (read_req && read_allowed) q.push_back('{tr_adx, mem[tr_adx[5:4]]});
      if (inject_valid) q.push_back('{inject_adx, inject_data});
      if (q.size() > 0) begin
        has_return_data <= !hold_return;
        return_adx      <= q[0].adx;
        return_data     <= q[0].data;
      end else begin
        has_return_data <= 1'b0;
      end
    end
  end

  typedef struct {
    logic        wa;
    logic        wr;
    logic        rr;
    logic [26:0] adx;
    logic        get;
    logic [15:0] pc;
    logic [15:0] ec;
    logic        busy;
  } vec_t;
  vec_t vecs[19];

  task automatic check_all_zero(input string tag);
    check({tag, " write_req"},   128'(write_req), 128'd0);
    check({tag, " read_req"},    128'(read_req), 128'd0);
    check({tag, " get"},         128'(get_return_data), 128'd0);
    check({tag, " busy"},        128'(busy), 128'd0);
    check({tag, " error_flag"},  128'(error_flag), 128'd0);
    check({tag, " tr_adx"},      128'(tr_adx), 128'd0);
    check({tag, " tr_wr_data"},  tr_wr_data, 128'd0);
    check({tag, " pass_count"},  128'(pass_count), 128'd0);
    check({tag, " error_count"}, 128'(error_count), 128'd0);
  endtask

  initial begin
    int base_pops;
    // Pass 0: write_allowed toggles 1,0,0,1 and line 32 is corrupted in memory.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 27'd0,  1'b0, 16'd0, 16'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 27'd0,  1'b0, 16'd0, 16'd0, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 27'd16, 1'b0, 16'd0, 16'd0, 1'b1};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 27'd16, 1'b0, 16'd0, 16'd0, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 27'd16, 1'b0, 16'd0, 16'd0, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 27'd32, 1'b0, 16'd0, 16'd0, 1'b1};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 27'd48, 1'b0, 16'd0, 16'd0, 1'b1};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 27'd0,  1'b0, 16'd0, 16'd0, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 27'd0,  1'b0, 16'd0, 16'd0, 1'b1};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 27'd16, 1'b0, 16'd0, 16'd0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 27'd0,  1'b1, 16'd0, 16'd0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 27'd32, 1'b0, 16'd0, 16'd0, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 27'd0,  1'b1, 16'd0, 16'd0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 27'd48, 1'b0, 16'd0, 16'd0, 1'b1};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 27'd0,  1'b1, 16'd0, 16'd0, 1'b1};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 27'd0,  1'b0, 16'd0, 16'd1, 1'b1};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 27'd0,  1'b1, 16'd0, 16'd1, 1'b1};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 27'd0,  1'b0, 16'd0, 16'd1, 1'b1};
    vecs[18] = '{1'b1, 1'b1, 1'b0, 27'd0,  1'b0, 16'd1, 16'd1, 1'b1};

    resetn = 1'b0; enable = 1'b0; write_allowed = 1'b0; read_allowed = 1'b1;
    writes_pending = 1'b0; reads_pending = 1'b0;
    corrupt_en = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;
    enable = 1'b1;

    for (int r = 0; r < 19; r++) begin
      write_allowed = vecs[r].wa;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("row%0d write_req", r),   128'(write_req), 128'(vecs[r].wr));
      check($sformatf("row%0d read_req", r),    128'(read_req), 128'(vecs[r].rr));
      check($sformatf("row%0d get", r),         128'(get_return_data), 128'(vecs[r].get));
      check($sformatf("row%0d pass_count", r),  128'(pass_count), 128'(vecs[r].pc));
      check($sformatf("row%0d error_count", r), 128'(error_count), 128'(vecs[r].ec));
      check($sformatf("row%0d busy", r),        128'(busy), 128'(vecs[r].busy));
      if (vecs[r].wr || vecs[r].rr)
        check($sformatf("row%0d tr_adx", r), 128'(tr_adx), 128'(vecs[r].adx));
      if (vecs[r].wr)
        check($sformatf("row%0d tr_wr_data", r), tr_wr_data, exp_pattern(vecs[r].adx, vecs[r].pc[7:0]));
      if (r == 7) begin
        for (int a = 0; a < 4; a++)
          check($sformatf("write_once adx%0d", a * 16), 128'(wcount[a]), 128'd1);
      end
    end
    check("pass0 error_flag", 128'(error_flag), 128'd1);

    // Pass 1: clean memory, back-to-back writes, then reads stall on the cap.
    corrupt_en = 1'b0;
    hold_return = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("p1 wr%0d req", i + 1), 128'(write_req), 128'd1);
      check($sformatf("p1 wr%0d adx", i + 1), 128'(tr_adx), 128'((i + 1) * 16));
      check($sformatf("p1 wr%0d data", i + 1), tr_wr_data, exp_pattern(27'((i + 1) * 16), 8'd1));
    end
    @(posedge clk);
    @(negedge clk);
    check("p1 wdrain write_req", 128'(write_req), 128'd0);

    for (int n = 0; n < 20 && read_req !== 1'b1; n++) @(negedge clk);
    check("p1 read start", 128'(read_req), 128'd1);
    @(posedge clk); @(negedge clk);
    check("cap read_req after 1", 128'(read_req), 128'd1);
    @(posedge clk); @(negedge clk);
    check("cap read_req after 2", 128'(read_req), 128'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      check($sformatf("cap hold rr%0d", i), 128'(read_req), 128'd0);
      check($sformatf("cap hold get%0d", i), 128'(get_return_data), 128'd0);
    end
    base_pops = pop_cnt;
    hold_return = 1'b0;
    for (int n = 0; n < 20 && read_req !== 1'b1; n++) @(negedge clk);
    check("cap resume read_req", 128'(read_req), 128'd1);
    check("cap resume pops", 128'(pop_cnt - base_pops), 128'd1);

    // enable dropped during READ: pass completes, then IDLE.
    enable = 1'b0;
    for (int n = 0; n < 100 && busy !== 1'b0; n++) @(negedge clk);
    check("drop busy", 128'(busy), 128'd0);
    check("drop pass_count", 128'(pass_count), 128'd2);
    check("drop write_req", 128'(write_req), 128'd0);
    check("drop error_count", 128'(error_count), 128'd1);
    check("drop error_flag", 128'(error_flag), 128'd1);
    repeat (3) @(negedge clk);
    check("idle stays", 128'(busy), 128'd0);

    // Misaligned return address with otherwise matching data.
    inject_adx = 27'd8;
    inject_data = exp_pattern(27'd8, 8'd2);
    inject_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    inject_valid = 1'b0;
    for (int n = 0; n < 10 && get_return_data !== 1'b1; n++) @(negedge clk);
    check("misalign pop", 128'(get_return_data), 128'd1);
    check("misalign count before", 128'(error_count), 128'd1);
    @(posedge clk); @(negedge clk);
    check("misalign count after", 128'(error_count), 128'd2);
    check("misalign get low", 128'(get_return_data), 128'd0);

    // Reset pulsed mid-WRITE.
    enable = 1'b1;
    write_allowed = 1'b1;
    for (int n = 0; n < 10 && write_req !== 1'b1; n++) @(negedge clk);
    check("p3 write start", 128'(write_req), 128'd1);
    @(posedge clk); @(negedge clk);
    check("p3 adx16", 128'(tr_adx), 128'd16);
    #2 resetn = 1'b0;
    #1 check_all_zero("async reset");
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); @(negedge clk);
    check("restart idle", 128'(write_req), 128'd0);
    @(posedge clk); @(negedge clk);
    check("restart write_req", 128'(write_req), 128'd1);
    check("restart tr_adx", 128'(tr_adx), 128'd0);
    check("restart data", tr_wr_data, exp_pattern(27'd0, 8'd0));
    check("restart busy", 128'(busy), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
